alu_pattern_applier: RTL
========================

// Module: alu_pattern_applier
// PURPOSE
//  On-chip stimulus/response stage placed directly upstream and downstream of the 2-bit alu.
//  Holds a small table of non-scan test patterns (PI vector, expected PO, PO mask) and applies
//  them to ain/bin/sel one at a time. After a fixed settle time it captures zout, compares
//  the masked bits, counts failures and compacts the responses into a MISR signature.
// PARAMETERS
//  DEPTH          8     pattern table entries (power of 2, >=2)
//  SETTLE_CYCLES  4     cycles between driving a pattern and strobing zout (>=1)
//  SIG_W          8     MISR width
//  SIG_POLY       8'h1D MISR feedback polynomial (taps XORed in when sig MSB = 1)
// PORTS
//  clk            in   1      single clock; all state changes on rising edge
//  rst_n          in   1      asynchronous, active-low reset
//  cfg_we         in   1      table write strobe; ignored while busy
//  cfg_addr       in   $clog2(DEPTH) table entry index
//  cfg_pi         in   5      {ain[1:0], bin[1:0], sel}, MSB first
//  cfg_xpct       in   2      expected {zout[1], zout[0]}
//  cfg_mask       in   2      1 = compare that bit; 0 = don't care (X)
//  cfg_npat       in   $clog2(DEPTH)+1  number of patterns to run (0..DEPTH), sampled on start
//  start          in   1      1-cycle pulse; accepted only in IDLE or DONE
//  ain            out  2      to alu
//  bin            out  2      to alu
//  sel            out  1      to alu
//  zout           in   2      from alu
//  busy           out  1      high from the cycle after start until DONE is entered
//  done           out  1      level; high in DONE until the next accepted start
//  pass           out  1      valid while done: 1 iff fail_count == 0
//  fail_count     out  8      patterns with >=1 masked mismatch; saturates at 255
//  first_fail     out  $clog2(DEPTH) index of the first failing pattern; 0 if none
//  signature      out  SIG_W  MISR state
// BEHAVIOUR
//  Reset: ain=bin=0, sel=0, busy=0, done=0, pass=0, fail_count=0, first_fail=0,
//   signature=0, FSM=IDLE. The table is not reset; its contents are undefined until written.
//  Reset mid-run aborts immediately to these values.
//  FSM: IDLE -start-> APPLY; APPLY (1 cycle) -> SETTLE; SETTLE counts SETTLE_CYCLES -> CAPTURE;
//   CAPTURE (1 cycle) -> APPLY if more patterns remain, else DONE; DONE -start-> APPLY.
//  start with npat=0: goes to DONE on the next cycle with pass=1, fail_count=0, signature=0.
//  On an accepted start: clear fail_count, first_fail and signature; latch npat; set idx=0.
//  APPLY: registered ain/bin/sel <= table[idx].pi. They hold through SETTLE and CAPTURE.
//   After the last pattern they keep their last value.
//  CAPTURE: mis = (zout ^ xpct) & mask. If |mis: fail_count++ (saturating), and set
//   first_fail=idx if this is the first failure. X or Z on a masked zout bit counts as a
//   mismatch. Unmasked bits are never compared.
//  MISR update in CAPTURE only:
//   sig <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? SIG_POLY : 0) ^ {{SIG_W-2{1'b0}}, zout & mask}.
//   Masked-off bits enter as 0, so X never reaches the signature.
//  Per-pattern latency is SETTLE_CYCLES+2 cycles. Total run = npat*(SETTLE_CYCLES+2) cycles,
//   from the first APPLY to DONE entry.
//  start while busy: ignored. cfg_we while busy: ignored. cfg_we in the same cycle as an
//   accepted start: the write is ignored. npat > DEPTH: clamped to DEPTH.
//  idx runs 0..npat-1; no wrap. The DONE outputs hold until the next start.
// STRUCTURE
//  Shared package alu_test_pkg: PI_W=5, PO_W=2, typedef struct {pi, xpct, mask} pat_t,
//   FSM state enum {IDLE, APPLY, SETTLE, CAPTURE, DONE}.
//  One sub-module: alu_misr (SIG_W, SIG_POLY; en, din[1:0], clr, sig).
//   Table, FSM and counters stay in the top.
// TESTING
//  1 Load {11101,10,11},{01101,00,11},{01111,01,01}; npat=3; good alu -> done, pass=1,
//    fail_count=0, busy for 3*(SETTLE+2) cycles.
//  2 Same table, zout[1] stuck-at-0 -> fail_count=1, first_fail=0, pass=0,
//    signature differs from scenario 1.
//  3 Pattern 2 with zout[1] driven X -> no failure and the same signature as scenario 1
//    (the mask blocks X).
//  4 npat=0 start -> done one cycle later, pass=1, signature=0; ain/bin/sel unchanged.
//  5 rst_n low during SETTLE of pattern 1 -> all outputs take reset values asynchronously;
//    a re-run after reset gives the same result as scenario 1.
//  6 start and cfg_we pulsed while busy -> run result and table unchanged;
//    force 300 failures -> fail_count=255.

Source files
------------

// File: rtl/alu_test_pkg.sv
// alu_test_pkg: shared types for the alu pattern applier.
// Pattern record layout and run-sequencer states.
package alu_test_pkg;

    localparam int PI_W   = 5;
    localparam int PO_W   = 2;
    localparam int FCNT_W = 8;

    typedef struct packed {
        logic [PI_W-1:0] pi;
        logic [PO_W-1:0] xpct;
        logic [PO_W-1:0] mask;
    } pat_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_APPLY   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/alu_misr.sv
// alu_misr: serial-shift multiple-input signature register.
// Compacts the masked 2-bit alu response once per captured pattern.
module alu_misr
    import alu_test_pkg::*;
#(
    parameter int               SIG_W    = 8,
    parameter logic [SIG_W-1:0] SIG_POLY = 8'h1D
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            clr,
    input  logic [PO_W-1:0] din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] r_sig;
    logic [SIG_W-1:0] w_next;
    logic [SIG_W-1:0] w_fb;

    // Next signature: shift left, fold back the polynomial, inject data
    always_comb begin
        w_fb   = r_sig[SIG_W-1] ? SIG_POLY : '0;
        w_next = {r_sig[SIG_W-2:0], 1'b0}
               ^ w_fb
               ^ {{(SIG_W-PO_W){1'b0}}, din};
    end

    // Signature state: cleared per run, advanced on capture only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= '0;
        end else if (clr) begin
            r_sig <= '0;
        end else if (en) begin
            r_sig <= w_next;
        end
    end

    assign sig = r_sig;

endmodule

// File: rtl/alu_pattern_applier.sv
// alu_pattern_applier: applies stored PI vectors to the 2-bit alu,
// strobes zout after a settle time, scores masked bits and builds a MISR.
module alu_pattern_applier
    import alu_test_pkg::*;
#(
    parameter int               DEPTH         = 8,
    parameter int               SETTLE_CYCLES = 4,
    parameter int               SIG_W         = 8,
    parameter logic [SIG_W-1:0] SIG_POLY      = 8'h1D
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_we,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr,
    input  logic [PI_W-1:0]          cfg_pi,
    input  logic [PO_W-1:0]          cfg_xpct,
    input  logic [PO_W-1:0]          cfg_mask,
    input  logic [$clog2(DEPTH):0]   cfg_npat,
    input  logic                     start,
    output logic [1:0]               ain,
    output logic [1:0]               bin,
    output logic                     sel,
    input  logic [PO_W-1:0]          zout,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [FCNT_W-1:0]        fail_count,
    output logic [$clog2(DEPTH)-1:0] first_fail,
    output logic [SIG_W-1:0]         signature
);

    localparam int AW = $clog2(DEPTH);
    localparam int NW = AW + 1;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [NW-1:0]     NPAT_MAX = NW'(DEPTH);
    localparam logic [CW-1:0]     CNT_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [FCNT_W-1:0] FAIL_MAX = {FCNT_W{1'b1}};

    state_t            r_state;
    logic [AW-1:0]     r_idx;
    logic [NW-1:0]     r_npat;
    logic [CW-1:0]     r_cnt;
    pat_t              r_tab [DEPTH];
    logic [1:0]        r_ain;
    logic [1:0]        r_bin;
    logic              r_sel;
    logic [FCNT_W-1:0] r_fail;
    logic [AW-1:0]     r_ff;

    logic              w_idle_like;
    logic              w_start_ok;
    logic              w_busy;
    logic              w_done;
    logic              w_we_ok;
    logic [NW-1:0]     w_npat;
    logic              w_last;
    logic              w_settled;
    logic              w_capture;
    pat_t              w_cur;
    logic              w_match;
    logic [PO_W-1:0]   w_din;
    logic [SIG_W-1:0]  w_sig;

    assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_start_ok  = start && w_idle_like;
    assign w_busy      = (r_state == ST_APPLY)
                      || (r_state == ST_SETTLE)
                      || (r_state == ST_CAPTURE);
    assign w_done      = (r_state == ST_DONE);
    assign w_we_ok     = cfg_we && w_idle_like && !w_start_ok;
    assign w_npat      = (cfg_npat > NPAT_MAX) ? NPAT_MAX : cfg_npat;
    assign w_last      = ({1'b0, r_idx} == (r_npat - 1'b1));
    assign w_settled   = (r_cnt == CNT_LAST);
    assign w_capture   = (r_state == ST_CAPTURE);
    assign w_cur       = r_tab[r_idx];

    // An X/Z on a compared bit leaves w_match unknown, which the
    // scoring branch below treats as a mismatch.
    assign w_match = &(~w_cur.mask | ~(zout ^ w_cur.xpct));
    assign w_din   = zout & w_cur.mask;

    // Pattern table write port; frozen while a run is in flight
    always_ff @(posedge clk) begin
        if (w_we_ok) begin
            r_tab[cfg_addr] <= '{pi: cfg_pi, xpct: cfg_xpct, mask: cfg_mask};
        end
    end

    // Run sequencer: apply, settle, capture per pattern
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_npat  <= '0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_ok) begin
                        r_idx   <= '0;
                        r_npat  <= w_npat;
                        r_state <= (w_npat == '0) ? ST_DONE : ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    r_cnt   <= '0;
                    r_state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (w_settled) begin
                        r_state <= ST_CAPTURE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (w_last) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= ST_APPLY;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Registered alu stimulus; holds between APPLY strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ain <= '0;
            r_bin <= '0;
            r_sel <= 1'b0;
        end else if (r_state == ST_APPLY) begin
            {r_ain, r_bin, r_sel} <= w_cur.pi;
        end
    end

    // Per-run scoring: clear on start, count failing patterns on capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail <= '0;
            r_ff   <= '0;
        end else if (w_start_ok) begin
            r_fail <= '0;
            r_ff   <= '0;
        end else if (w_capture) begin
            if (w_match) begin
                r_fail <= r_fail;
            end else begin
                if (r_fail != FAIL_MAX) begin
                    r_fail <= r_fail + 1'b1;
                end
                if (r_fail == '0) begin
                    r_ff <= r_idx;
                end
            end
        end
    end

    alu_misr #(
        .SIG_W    (SIG_W),
        .SIG_POLY (SIG_POLY)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_capture),
        .clr   (w_start_ok),
        .din   (w_din),
        .sig   (w_sig)
    );

    assign ain        = r_ain;
    assign bin        = r_bin;
    assign sel        = r_sel;
    assign busy       = w_busy;
    assign done       = w_done;
    assign pass       = w_done && (r_fail == '0);
    assign fail_count = r_fail;
    assign first_fail = r_ff;
    assign signature  = w_sig;

endmodule
